slot_game_ctrl: RTL and testbench
=================================

Name: slot_game_ctrl

Overview:
Game-logic stage directly upstream of the VGA display controller in the slot-machine design. It owns the credit balance, three 2-bit reel positions, spin/stop sequencing and win evaluation. Its outputs `money`, `reel_pos0..2` and `stop` drive the display controller's credit digits and reel rotation states. Buttons arrive already debounced and synchronised to `clk`, active-high.

Parameters:
COIN_VALUE, 10, credit added per coin press
BET, 5, credit debited per spin
MAX_MONEY, 999, saturation ceiling for money
SPIN_FRAMES, 60, frames until reel0 auto-stops
STAGGER_FRAMES, 30, extra frames per subsequent reel auto-stop
PAYOUT3, 50, credit for three matching reels
PAYOUT2, 10, credit for reel0==reel1 only
RESULT_FRAMES, 90, frames the result is held before returning to IDLE

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
frame_tick  in  1  one-cycle pulse per video frame
btn_coin  in  1  add credit (level; rising edge acts)
btn_spin  in  1  start spin (level; rising edge acts)
btn_stop  in  1  manually stop next running reel (level; rising edge acts)
money  out  10  current credit, 0..MAX_MONEY
reel_pos0  out  2  reel 0 symbol position
reel_pos1  out  2  reel 1 symbol position
reel_pos2  out  2  reel 2 symbol position
stop  out  1  high when all reels are stopped
spinning  out  1  high in SPIN state
win  out  1  high in SHOW state when last payout > 0

Behaviour:
- Clock `clk`, reset `rst`: one clock, synchronous active-high reset. All state updates on the rising edge of `clk`.
- Reset values: money=0; reel_pos0/1/2=0/1/2; stop=1; spinning=0; win=0; state=IDLE; frame_cnt=0.
  - Button-previous registers reset to 1, so a button held through reset produces no edge.
  - Reset mid-spin discards the spin; the bet is not refunded.
- Edge detect: press = btn & ~btn_prev. Each press is acted on exactly once.
- frame_cnt is 8 bits. Parameters must satisfy SPIN_FRAMES + 2*STAGGER_FRAMES ≤ 255 and RESULT_FRAMES ≤ 255.
- States: IDLE, SPIN, EVAL, SHOW.
- IDLE:
  - Spin press with money ≥ BET: money -= BET, frame_cnt=0, all reels set running, go to SPIN.
  - Spin press with money < BET: ignored.
- SPIN:
  - On each frame_tick: frame_cnt += 1, and every running reel increments its position mod 4 (3 wraps to 0).
  - Reel i stops after the tick where the new frame_cnt == SPIN_FRAMES + i*STAGGER_FRAMES.
  - Stop press: the lowest-index running reel stops immediately; no further advance, including on a same-cycle frame_tick.
  - Auto-stop still applies to reels not stopped manually.
  - When all three reels are stopped, go to EVAL on the next cycle.
  - Spin presses are ignored in SPIN.
- EVAL (1 cycle):
  - payout = PAYOUT3 if pos0==pos1==pos2; else PAYOUT2 if pos0==pos1; else 0.
  - money = min(money + payout, MAX_MONEY).
  - win <= (payout ≠ 0); frame_cnt=0; go to SHOW.
- SHOW:
  - frame_cnt counts frame_ticks; on reaching RESULT_FRAMES, win=0 and go to IDLE.
  - Spin and stop presses are ignored.
- Coin press: accepted in every state, money = min(money + COIN_VALUE, MAX_MONEY).
  - Coincident with the IDLE debit: money = money − BET + COIN_VALUE, checked against the pre-update money ≥ BET.
  - Coincident with the EVAL payout: money = min(money + payout + COIN_VALUE, MAX_MONEY).
  - Arithmetic is done at 11 bits before saturation; money never underflows.
- Output flags: stop = all three reels stopped (combinational from the per-reel stopped flags). spinning = (state==SPIN).

Test Plan:
- Reset, then one coin press → money=10, reel_pos=0/1/2, stop=1, spinning=0.
- money=0, spin press → state stays IDLE, money=0, reels static across 5 frame_ticks.
- Override SPIN_FRAMES=4, STAGGER_FRAMES=3. From reset: coin, spin → money=5. Reels stop after ticks 4/7/10 at pos 0/0/0; EVAL → money=55, win=1. After 90 ticks win=0 and state is IDLE.
- Defaults: coin, spin, 2 frame_ticks, stop press → reel_pos0 frozen at 2 through later ticks. Reels 1/2 auto-stop at frame_cnt 90/120 with pos 3/2; no win; money=5.
- 100 coin presses → money saturates at 999. Spin → 994; a coin in the same cycle as the spin press → 999.
- Reset asserted mid-SPIN while btn_spin is held → money=0, state IDLE, pos 0/1/2. No spin starts after reset until btn_spin is released and pressed again.

Source files
------------

// File: rtl/slot_game_ctrl_if.sv
// Button/frame inputs and credit/reel outputs exchanged between the slot
// game logic and its surroundings (buttons in, display controller out).
interface slot_game_ctrl_if;
  logic       frame_tick;
  logic       btn_coin;
  logic       btn_spin;
  logic       btn_stop;
  logic [9:0] money;
  logic [1:0] reel_pos0;
  logic [1:0] reel_pos1;
  logic [1:0] reel_pos2;
  logic       stop;
  logic       spinning;
  logic       win;

  modport master (
    output frame_tick, btn_coin, btn_spin, btn_stop,
    input  money, reel_pos0, reel_pos1, reel_pos2, stop, spinning, win
  );

  modport slave (
    input  frame_tick, btn_coin, btn_spin, btn_stop,
    output money, reel_pos0, reel_pos1, reel_pos2, stop, spinning, win
  );
endinterface

// File: rtl/slot_game_ctrl.sv
// Slot-machine game logic: credit balance, three 2-bit reels, spin/stop
// sequencing and win evaluation feeding the VGA display controller.
//
// state | meaning
// IDLE  | waiting for a spin press with enough credit
// SPIN  | reels advance on frame ticks until each stops (manual or auto)
// EVAL  | one cycle: payout added to credit, win flag set
// SHOW  | result held for RESULT_FRAMES frames, then back to IDLE
module slot_game_ctrl #(
  parameter int COIN_VALUE     = 10,
  parameter int BET            = 5,
  parameter int MAX_MONEY      = 999,
  parameter int SPIN_FRAMES    = 60,
  parameter int STAGGER_FRAMES = 30,
  parameter int PAYOUT3        = 50,
  parameter int PAYOUT2        = 10,
  parameter int RESULT_FRAMES  = 90
) (
  input logic             clk,
  input logic             rst,
  slot_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SPIN, EVAL, SHOW} state_t;

  localparam logic [10:0] COIN_W  = 11'(COIN_VALUE);
  localparam logic [10:0] BET_W   = 11'(BET);
  localparam logic [10:0] MAX_W   = 11'(MAX_MONEY);
  localparam logic [10:0] PAY3_W  = 11'(PAYOUT3);
  localparam logic [10:0] PAY2_W  = 11'(PAYOUT2);
  localparam logic [7:0]  RESULT_W = 8'(RESULT_FRAMES);
  localparam logic [2:0][7:0] STOP_AT = {8'(SPIN_FRAMES + 2 * STAGGER_FRAMES),
                                         8'(SPIN_FRAMES + STAGGER_FRAMES),
                                         8'(SPIN_FRAMES)};

  state_t          r_state, w_state_nxt;
  logic [9:0]      r_money, w_money_nxt;
  logic [7:0]      r_frame_cnt, w_frame_cnt_nxt, w_cnt_inc;
  logic [2:0][1:0] r_pos, w_pos_nxt;
  logic [2:0]      r_stopped, w_stopped_nxt;
  logic            r_win, w_win_nxt;
  logic            r_coin_prev, r_spin_prev, r_stop_prev;
  logic            w_coin_press, w_spin_press, w_stop_press;
  logic [2:0]      w_running, w_lowest;
  logic [10:0]     w_payout, w_sum;
  logic            w_debit;

  assign w_coin_press = bus.btn_coin & ~r_coin_prev;
  assign w_spin_press = bus.btn_spin & ~r_spin_prev;
  assign w_stop_press = bus.btn_stop & ~r_stop_prev;
  assign w_cnt_inc    = r_frame_cnt + 8'd1;
  assign w_running    = ~r_stopped;
  // One-hot of the lowest-index running reel (two's complement isolate).
  assign w_lowest     = w_running & (~w_running + 3'd1);

  always_comb begin
    w_payout = '0;
    if (r_pos[0] == r_pos[1] && r_pos[1] == r_pos[2]) w_payout = PAY3_W;
    else if (r_pos[0] == r_pos[1])                   w_payout = PAY2_W;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_pos_nxt       = r_pos;
    w_stopped_nxt   = r_stopped;
    w_win_nxt       = r_win;
    w_debit         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_spin_press && ({1'b0, r_money} >= BET_W)) begin
          w_debit         = 1'b1;
          w_frame_cnt_nxt = '0;
          w_stopped_nxt   = '0;
          w_state_nxt     = SPIN;
        end
      end
      SPIN: begin
        if (&r_stopped) begin
          w_state_nxt = EVAL;
        end else begin
          // A manually stopped reel must not advance on a coincident tick.
          w_stopped_nxt = r_stopped | (w_stop_press ? w_lowest : 3'b000);
          if (bus.frame_tick) begin
            w_frame_cnt_nxt = w_cnt_inc;
            for (int i = 0; i < 3; i++) begin
              if (!w_stopped_nxt[i]) begin
                w_pos_nxt[i] = r_pos[i] + 2'd1;
                if (w_cnt_inc == STOP_AT[i]) w_stopped_nxt[i] = 1'b1;
              end
            end
          end
        end
      end
      EVAL: begin
        w_win_nxt       = (w_payout != '0);
        w_frame_cnt_nxt = '0;
        w_state_nxt     = SHOW;
      end
      SHOW: begin
        if (bus.frame_tick) begin
          w_frame_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == RESULT_W) begin
            w_win_nxt   = 1'b0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Coin is added before the debit, so the 11-bit sum cannot underflow.
    w_sum = {1'b0, r_money};
    if (w_coin_press)      w_sum = w_sum + COIN_W;
    if (w_debit)           w_sum = w_sum - BET_W;
    if (r_state == EVAL)   w_sum = w_sum + w_payout;
    w_money_nxt = (w_sum > MAX_W) ? MAX_W[9:0] : w_sum[9:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_money     <= '0;
      r_frame_cnt <= '0;
      r_pos       <= {2'd2, 2'd1, 2'd0};
      r_stopped   <= 3'b111;
      r_win       <= 1'b0;
      r_coin_prev <= 1'b1;
      r_spin_prev <= 1'b1;
      r_stop_prev <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_money     <= w_money_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_pos       <= w_pos_nxt;
      r_stopped   <= w_stopped_nxt;
      r_win       <= w_win_nxt;
      r_coin_prev <= bus.btn_coin;
      r_spin_prev <= bus.btn_spin;
      r_stop_prev <= bus.btn_stop;
    end
  end

  assign bus.money     = r_money;
  assign bus.reel_pos0 = r_pos[0];
  assign bus.reel_pos1 = r_pos[1];
  assign bus.reel_pos2 = r_pos[2];
  assign bus.stop      = &r_stopped;
  assign bus.spinning  = (r_state == SPIN);
  assign bus.win       = r_win;

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Bench for slot_game_ctrl: directed scenarios plus a randomized run against
// a game-rule reference model, on a default and a fast-spin instance.
module tb_slot_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, coin = 1'b0, spin = 1'b0, stp = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state, index 0 = default instance, 1 = fast instance.
  int m_ph [2];      // 0 idle, 1 spinning, 2 evaluating, 3 showing
  int m_money [2];
  int m_pos [2][3];
  bit m_run [2][3];
  int m_frames [2];
  bit m_win [2];
  bit m_pc [2], m_ps [2], m_pt [2];

  slot_game_ctrl_if ifa ();
  slot_game_ctrl_if ifb ();

  assign ifa.frame_tick = tick;
  assign ifa.btn_coin   = coin;
  assign ifa.btn_spin   = spin;
  assign ifa.btn_stop   = stp;
  assign ifb.frame_tick = tick;
  assign ifb.btn_coin   = coin;
  assign ifb.btn_spin   = spin;
  assign ifb.btn_stop   = stp;

  slot_game_ctrl u_a (.clk(clk), .rst(rst), .bus(ifa));
  slot_game_ctrl #(.SPIN_FRAMES(4), .STAGGER_FRAMES(3)) u_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    tick = 1'b1; cyc();
    tick = 1'b0; cyc();
  endtask

  task automatic press_coin();
    coin = 1'b1; cyc();
    coin = 1'b0; cyc();
  endtask

  task automatic press_spin();
    spin = 1'b1; cyc();
    spin = 1'b0; cyc();
  endtask

  task automatic do_reset();
    tick = 0; coin = 0; spin = 0; stp = 0;
    rst = 1'b1; cyc(); cyc();
    rst = 1'b0; cyc();
  endtask

  function automatic int stop_frame(int k, int i);
    return (k == 0) ? 60 + 30 * i : 4 + 3 * i;
  endfunction

  // Applies one clock edge of the game rules to model instance k.
  task automatic mstep(input int k, input bit r, input bit tk, input bit c,
                       input bit s, input bit p);
    int  add, pay, idx;
    bit  pc, ps, pp;
    if (r) begin
      m_ph[k] = 0; m_money[k] = 0; m_frames[k] = 0; m_win[k] = 0;
      for (int i = 0; i < 3; i++) begin m_pos[k][i] = i; m_run[k][i] = 0; end
      m_pc[k] = 1; m_ps[k] = 1; m_pt[k] = 1;
      return;
    end
    pc = c && !m_pc[k]; ps = s && !m_ps[k]; pp = p && !m_pt[k];
    m_pc[k] = c; m_ps[k] = s; m_pt[k] = p;
    add = pc ? 10 : 0;
    case (m_ph[k])
      0: if (ps && m_money[k] >= 5) begin
           add -= 5; m_ph[k] = 1; m_frames[k] = 0;
           for (int i = 0; i < 3; i++) m_run[k][i] = 1;
         end
      1: if (!(m_run[k][0] || m_run[k][1] || m_run[k][2])) m_ph[k] = 2;
         else begin
           idx = -1;
           if (pp) for (int i = 2; i >= 0; i--) if (m_run[k][i]) idx = i;
           if (idx >= 0) m_run[k][idx] = 0;
           if (tk) begin
             m_frames[k]++;
             for (int i = 0; i < 3; i++)
               if (m_run[k][i]) begin
                 m_pos[k][i] = (m_pos[k][i] + 1) % 4;
                 if (m_frames[k] == stop_frame(k, i)) m_run[k][i] = 0;
               end
           end
         end
      2: begin
           if (m_pos[k][0] == m_pos[k][1] && m_pos[k][1] == m_pos[k][2]) pay = 50;
           else if (m_pos[k][0] == m_pos[k][1]) pay = 10;
           else pay = 0;
           add += pay; m_win[k] = (pay != 0); m_frames[k] = 0; m_ph[k] = 3;
         end
      default: if (tk) begin
           m_frames[k]++;
           if (m_frames[k] == 90) begin m_win[k] = 0; m_ph[k] = 0; end
         end
    endcase
    m_money[k] = (m_money[k] + add > 999) ? 999 : m_money[k] + add;
  endtask

  function automatic logic [18:0] get_obs(int k);
    if (k == 0) return {ifa.money, ifa.reel_pos0, ifa.reel_pos1, ifa.reel_pos2,
                        ifa.stop, ifa.spinning, ifa.win};
    return {ifb.money, ifb.reel_pos0, ifb.reel_pos1, ifb.reel_pos2,
            ifb.stop, ifb.spinning, ifb.win};
  endfunction

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({ifa.money, ifa.reel_pos0, ifa.reel_pos1, ifa.reel_pos2, ifa.stop, ifa.spinning, ifa.win}
        !== {10'd0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_state: got money=%0d pos=%0d/%0d/%0d stop=%b spin=%b win=%b",
        ifa.money, ifa.reel_pos0, ifa.reel_pos1, ifa.reel_pos2, ifa.stop, ifa.spinning, ifa.win);
    end
    press_coin();
    n_vec++;
    if (ifa.money !== 10'd10 || ifa.stop !== 1'b1 || ifa.spinning !== 1'b0) begin
      n_err++; $display("FAIL first_coin: money=%0d stop=%b spin=%b, want 10/1/0",
        ifa.money, ifa.stop, ifa.spinning);
    end
  endtask

  task automatic test_no_credit();
    do_reset();
    press_spin();
    n_vec++;
    if (ifa.spinning !== 1'b0 || ifa.money !== 10'd0) begin
      n_err++; $display("FAIL no_credit_spin: spin=%b money=%0d, want 0/0", ifa.spinning, ifa.money);
    end
    repeat (5) frame();
    n_vec++;
    if ({ifa.reel_pos0, ifa.reel_pos1, ifa.reel_pos2} !== {2'd0, 2'd1, 2'd2}) begin
      n_err++; $display("FAIL no_credit_static: pos=%0d/%0d/%0d, want 0/1/2",
        ifa.reel_pos0, ifa.reel_pos1, ifa.reel_pos2);
    end
  endtask

  task automatic test_fast_win();
    int waited;
    do_reset();
    press_coin();
    press_spin();
    n_vec++;
    if (ifb.money !== 10'd5 || ifb.spinning !== 1'b1) begin
      n_err++; $display("FAIL fast_bet: money=%0d spin=%b, want 5/1", ifb.money, ifb.spinning);
    end
    for (int t = 1; t <= 10; t++) begin
      frame();
      if (t == 4) begin
        n_vec++;
        if (ifb.reel_pos0 !== 2'd0 || ifb.stop !== 1'b0) begin
          n_err++; $display("FAIL fast_reel0: pos0=%0d stop=%b, want 0/0", ifb.reel_pos0, ifb.stop);
        end
      end
      if (t == 7) begin
        n_vec++;
        if (ifb.reel_pos0 !== 2'd0 || ifb.reel_pos1 !== 2'd0) begin
          n_err++; $display("FAIL fast_reel1: pos=%0d/%0d, want 0/0", ifb.reel_pos0, ifb.reel_pos1);
        end
      end
    end
    waited = 0;
    while (ifb.win !== 1'b1 && waited < 8) begin cyc(); waited++; end
    n_vec++;
    if (ifb.win !== 1'b1 || ifb.money !== 10'd55 ||
        {ifb.reel_pos0, ifb.reel_pos1, ifb.reel_pos2} !== 6'd0) begin
      n_err++; $display("FAIL fast_eval: win=%b money=%0d pos=%0d/%0d/%0d, want 1/55/0/0/0",
        ifb.win, ifb.money, ifb.reel_pos0, ifb.reel_pos1, ifb.reel_pos2);
    end
    repeat (89) frame();
    n_vec++;
    if (ifb.win !== 1'b1) begin
      n_err++; $display("FAIL show_hold: win=%b after 89 frames, want 1", ifb.win);
    end
    frame();
    n_vec++;
    if (ifb.win !== 1'b0 || ifb.spinning !== 1'b0) begin
      n_err++; $display("FAIL show_end: win=%b spin=%b, want 0/0", ifb.win, ifb.spinning);
    end
    press_spin();
    n_vec++;
    if (ifb.spinning !== 1'b1 || ifb.money !== 10'd50) begin
      n_err++; $display("FAIL back_to_idle: spin=%b money=%0d, want 1/50", ifb.spinning, ifb.money);
    end
  endtask

  task automatic test_manual_stop();
    int waited;
    do_reset();
    press_coin();
    press_spin();
    frame(); frame();
    stp = 1'b1; cyc(); stp = 1'b0; cyc();
    n_vec++;
    if (ifa.reel_pos0 !== 2'd2) begin
      n_err++; $display("FAIL manual_stop: pos0=%0d, want 2", ifa.reel_pos0);
    end
    for (int t = 3; t <= 120; t++) begin
      frame();
      if (t == 10 || t == 89) begin
        n_vec++;
        if (ifa.reel_pos0 !== 2'd2 || ifa.reel_pos1 !== 2'((1 + t) % 4)) begin
          n_err++; $display("FAIL manual_run t=%0d: pos0=%0d pos1=%0d, want 2/%0d",
            t, ifa.reel_pos0, ifa.reel_pos1, (1 + t) % 4);
        end
      end
    end
    n_vec++;
    if ({ifa.reel_pos0, ifa.reel_pos1, ifa.reel_pos2, ifa.stop} !== {2'd2, 2'd3, 2'd2, 1'b1}) begin
      n_err++; $display("FAIL auto_stop: pos=%0d/%0d/%0d stop=%b, want 2/3/2/1",
        ifa.reel_pos0, ifa.reel_pos1, ifa.reel_pos2, ifa.stop);
    end
    waited = 0;
    while (ifa.spinning !== 1'b0 && waited < 8) begin cyc(); waited++; end
    cyc(); cyc();
    n_vec++;
    if (ifa.spinning !== 1'b0 || ifa.win !== 1'b0 || ifa.money !== 10'd5) begin
      n_err++; $display("FAIL no_win: spin=%b win=%b money=%0d, want 0/0/5",
        ifa.spinning, ifa.win, ifa.money);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (100) press_coin();
    n_vec++;
    if (ifa.money !== 10'd999) begin
      n_err++; $display("FAIL saturate: money=%0d, want 999", ifa.money);
    end
    press_spin();
    n_vec++;
    if (ifa.money !== 10'd994) begin
      n_err++; $display("FAIL sat_spin: money=%0d, want 994", ifa.money);
    end
    do_reset();
    repeat (100) press_coin();
    coin = 1'b1; spin = 1'b1; cyc();
    coin = 1'b0; spin = 1'b0; cyc();
    n_vec++;
    if (ifa.money !== 10'd999 || ifa.spinning !== 1'b1) begin
      n_err++; $display("FAIL coin_with_spin: money=%0d spin=%b, want 999/1", ifa.money, ifa.spinning);
    end
  endtask

  task automatic test_reset_mid_spin();
    do_reset();
    press_coin();
    spin = 1'b1; cyc(); cyc();
    repeat (3) frame();
    rst = 1'b1; cyc(); cyc();
    rst = 1'b0; cyc();
    n_vec++;
    if ({ifa.money, ifa.reel_pos0, ifa.reel_pos1, ifa.reel_pos2, ifa.stop, ifa.spinning}
        !== {10'd0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL mid_spin_reset: money=%0d pos=%0d/%0d/%0d stop=%b spin=%b",
        ifa.money, ifa.reel_pos0, ifa.reel_pos1, ifa.reel_pos2, ifa.stop, ifa.spinning);
    end
    press_coin();
    repeat (2) frame();
    n_vec++;
    if (ifa.spinning !== 1'b0 || ifa.money !== 10'd10) begin
      n_err++; $display("FAIL held_spin: spin=%b money=%0d, want 0/10", ifa.spinning, ifa.money);
    end
    spin = 1'b0; cyc();
    spin = 1'b1; cyc();
    n_vec++;
    if (ifa.spinning !== 1'b1 || ifa.money !== 10'd5) begin
      n_err++; $display("FAIL repress_spin: spin=%b money=%0d, want 1/5", ifa.spinning, ifa.money);
    end
    spin = 1'b0; cyc();
  endtask

  task automatic test_random();
    logic [18:0] exp_v, obs_v;
    for (int n = 0; n < 6000; n++) begin
      rst  = (n == 0) || ($urandom_range(0, 1499) == 0);
      tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) coin = ~coin;
      if ($urandom_range(0, 7) == 0) spin = ~spin;
      if ($urandom_range(0, 5) == 0) stp  = ~stp;
      cyc();
      for (int k = 0; k < 2; k++) begin
        mstep(k, rst, tick, coin, spin, stp);
        exp_v = {10'(m_money[k]), 2'(m_pos[k][0]), 2'(m_pos[k][1]), 2'(m_pos[k][2]),
                 !(m_run[k][0] || m_run[k][1] || m_run[k][2]), m_ph[k] == 1, m_win[k]};
        obs_v = get_obs(k);
        n_vec++;
        if (obs_v !== exp_v) begin
          n_err++;
          if (n_err < 30) $display("FAIL random cyc=%0d inst=%0d: got %h want %h", n, k, obs_v, exp_v);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_credit();
    test_fast_win();
    test_manual_stop();
    test_saturation();
    test_reset_mid_spin();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
